exec_controller: RTL

EXEC_CONTROLLER -- requirements
Module: exec_controller

---
 rtl/exec_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/exec_controller.sv
// exec_controller: copies a program image from a source ROM into data memory,
// releases the CPU from reset, then watches the CPU's data-memory writes for a
// completion store at DONE_ADR. A watchdog bounds the number of RUN cycles.
module exec_controller #(
  parameter int          LOAD_WORDS = 256,
  parameter logic [31:0] DONE_ADR   = 32'h64,
  parameter int          MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [15:0] src_adr,
  input  logic [31:0] src_data,
  output logic        ld_we,
  output logic [31:0] ld_adr,
  output logic [31:0] ld_data,
  output logic        cpu_rst,
  output logic        done,
  output logic        timeout,
  output logic [31:0] result,
  output logic [31:0] cycles
);

  localparam logic [15:0] LAST_IDX  = 16'(LOAD_WORDS - 1);
  localparam logic [31:0] CYC_SAT   = 32'(MAX_CYCLES);
  localparam logic [31:0] CYC_LIMIT = 32'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  state_t      state_q;
  logic        start_q;
  logic [15:0] idx_q;
  logic [31:0] cycles_q;
  logic [31:0] cycles_d;
  logic [31:0] result_q;
  logic        ld_we_q;
  logic        cpu_rst_q;
  logic        done_q;
  logic        timeout_q;

  logic        start_edge;
  logic        done_hit;

  assign start_edge = start & ~start_q;
  assign done_hit   = MemWrite && (DataAdr == DONE_ADR);

  // Saturating RUN-cycle count for the current edge.
  always_comb begin
    cycles_d = cycles_q;
    if (cycles_q != CYC_SAT) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  // Control FSM; all status outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      idx_q     <= 16'd0;
      cycles_q  <= 32'd0;
      result_q  <= 32'd0;
      ld_we_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        // A start edge from any resting state begins a fresh load.
        IDLE, DONE, TIMEOUT: begin
          if (start_edge) begin
            state_q   <= LOAD;
            idx_q     <= 16'd0;
            cycles_q  <= 32'd0;
            result_q  <= 32'd0;
            ld_we_q   <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        LOAD: begin
          idx_q <= idx_q + 16'd1;
          if (idx_q == LAST_IDX) begin
            state_q   <= RUN;
            ld_we_q   <= 1'b0;
            cpu_rst_q <= 1'b0;
          end
        end
        // Completion is tested first so it wins over the watchdog on a tie.
        RUN: begin
          cycles_q <= cycles_d;
          if (done_hit) begin
            state_q   <= DONE;
            result_q  <= WriteData;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b1;
          end else if (cycles_d == CYC_LIMIT) begin
            state_q   <= TIMEOUT;
            timeout_q <= 1'b1;
            cpu_rst_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          ld_we_q   <= 1'b0;
          cpu_rst_q <= 1'b1;
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  // The ROM is combinational, so its data passes straight to the write port.
  assign src_adr = idx_q;
  assign ld_adr  = {14'd0, idx_q, 2'b00};
  assign ld_data = src_data;
  assign ld_we   = ld_we_q;
  assign cpu_rst = cpu_rst_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign result  = result_q;
  assign cycles  = cycles_q;

endmodule
